// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its commit stage: condition codes,
// flag bit positions and ALU function encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4
  } alu_func_e;

endpackage

// File: rtl/alu_commit_cond_eval.sv
// Combinational ARM condition-code evaluation against an NZCV flag vector.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
  end

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_commit.sv
// Execute/commit stage alongside the ALU: tracks the issued op, evaluates its
// condition against architectural NZCV and drives the RF write, flags and counters.
module alu_commit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_wen,
  input  logic              iss_s,
  input  logic [3:0]        iss_cond,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        arch_flags,
  output logic              fwd_e_valid,
  output logic [REG_AW-1:0] fwd_e_rd,
  output logic [DATA_W-1:0] fwd_e_data,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  condfail_cnt
);

  logic              e_valid;
  logic [REG_AW-1:0] e_rd;
  logic              e_wen;
  logic              e_s;
  cond_e             e_cond;
  logic              pass;
  logic              commit;

  // Condition is judged against committed flags only; the ALU's own flags
  // may already reflect an op whose condition fails.
  cond_eval u_cond_eval (
    .cond (e_cond),
    .nzcv (arch_flags),
    .pass (pass)
  );

  always_comb begin
    commit      = e_valid & ~flush;
    fwd_e_valid = commit & e_wen & pass;
    fwd_e_rd    = e_rd;
    fwd_e_data  = alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid      <= 1'b0;
      e_rd         <= '0;
      e_wen        <= 1'b0;
      e_s          <= 1'b0;
      e_cond       <= COND_EQ;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      arch_flags   <= '0;
      retired_cnt  <= '0;
      condfail_cnt <= '0;
    end else begin
      e_valid  <= iss_valid & ~flush;
      e_rd     <= iss_rd;
      e_wen    <= iss_wen;
      e_s      <= iss_s;
      e_cond   <= cond_e'(iss_cond);
      rf_we    <= commit & e_wen & pass;
      rf_waddr <= e_rd;
      rf_wdata <= alu_result;
      if (commit & e_s & pass)
        arch_flags <= alu_flags;
      if (commit & pass)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (commit & ~pass)
        condfail_cnt <= condfail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_commit.sv
// Bench for alu_commit: directed vector table, hand sequences and random ops
// checked against a behavioural model; a 4-bit-counter instance covers wrap.
module tb_alu_commit;
  import alu_pkg::*;

  typedef struct {
    bit          v;
    logic [3:0]  rd;
    bit          wen;
    bit          s;
    logic [3:0]  cond;
    alu_func_e   fn;
    logic [31:0] a;
    logic [31:0] b;
    bit          fl;
  } op_t;

  typedef struct {
    op_t         op;
    bit          ewe;
    logic [3:0]  ewaddr;
    logic [31:0] ewdata;
    logic [3:0]  eflags;
    int unsigned eret;
    int unsigned ecf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [3:0]  iss_rd = '0;
  logic        iss_wen = 1'b0;
  logic        iss_s = 1'b0;
  logic [3:0]  iss_cond = '0;
  logic        flush = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;

  logic        rf_we, fwd_e_valid;
  logic [3:0]  rf_waddr, fwd_e_rd, arch_flags;
  logic [31:0] rf_wdata, fwd_e_data, retired_cnt, condfail_cnt;

  logic        s_rf_we, s_fwd_e_valid;
  logic [3:0]  s_rf_waddr, s_fwd_e_rd, s_arch_flags;
  logic [31:0] s_rf_wdata, s_fwd_e_data;
  logic [3:0]  s_retired_cnt, s_condfail_cnt;

  int total = 0;
  int bad   = 0;

  bit          m_ev;
  op_t         m_e;
  logic [31:0] m_eres;
  bit          m_we;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_flags;
  int unsigned m_ret, m_cf;

  alu_commit #(.DATA_W(32), .REG_AW(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .iss_s(iss_s), .iss_cond(iss_cond), .flush(flush),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .arch_flags(arch_flags), .fwd_e_valid(fwd_e_valid), .fwd_e_rd(fwd_e_rd),
    .fwd_e_data(fwd_e_data), .retired_cnt(retired_cnt),
    .condfail_cnt(condfail_cnt)
  );

  alu_commit #(.DATA_W(32), .REG_AW(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .iss_s(iss_s), .iss_cond(iss_cond), .flush(flush),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .arch_flags(s_arch_flags), .fwd_e_valid(s_fwd_e_valid),
    .fwd_e_rd(s_fwd_e_rd), .fwd_e_data(s_fwd_e_data),
    .retired_cnt(s_retired_cnt), .condfail_cnt(s_condfail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU stand-in: C is the unsigned carry of ADD only, V signed overflow of ADD/SUB.
  function automatic logic [35:0] alu_eval(input alu_func_e fn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (fn)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND: r = a & b;
      ALU_ORR: r = a | b;
      default: r = a ^ b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Conditions come in complementary pairs; odd codes invert the even predicate.
  function automatic bit ref_pass(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc == 4'hF) return 1'b0;
    return base ^ cc[0];
  endfunction

  function automatic op_t mkop(input bit v, input int rd, input bit wen, input bit s,
                               input int cond, input alu_func_e fn,
                               input logic [31:0] a, input logic [31:0] b, input bit fl);
    op_t o;
    o.v = v; o.rd = 4'(rd); o.wen = wen; o.s = s; o.cond = 4'(cond);
    o.fn = fn; o.a = a; o.b = b; o.fl = fl;
    return o;
  endfunction

  task automatic cycle(input op_t op, input bit r);
    bit          pass, commit;
    logic [35:0] ev;
    iss_valid = op.v; iss_rd = op.rd; iss_wen = op.wen; iss_s = op.s;
    iss_cond = op.cond; flush = op.fl; rst = r;
    #1;
    pass   = ref_pass(m_e.cond, m_flags);
    commit = m_ev && !op.fl;
    chk("fwd_valid", fwd_e_valid, commit && m_e.wen && pass);
    chk("s_fwd_valid", s_fwd_e_valid, commit && m_e.wen && pass);
    if (commit && m_e.wen && pass) chk("fwd_rd", fwd_e_rd, m_e.rd);
    chk("fwd_data", fwd_e_data, m_eres);
    if (r) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_flags = '0; m_ret = 0; m_cf = 0;
    end else begin
      m_we = commit && m_e.wen && pass;
      m_waddr = m_e.rd;
      m_wdata = m_eres;
      if (commit && m_e.s && pass) m_flags = alu_flags;
      if (commit && pass) m_ret++;
      if (commit && !pass) m_cf++;
    end
    m_ev = !r && op.v && !op.fl;
    m_e  = op;
    @(posedge clk);
    #1;
    ev = alu_eval(op.fn, op.a, op.b);
    alu_result = ev[31:0];
    if (op.s) alu_flags = ev[35:32];
    m_eres = ev[31:0];
    chk("rf_we", rf_we, m_we);
    chk("s_rf_we", s_rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("s_rf_wdata", s_rf_wdata, m_wdata);
      chk("s_rf_waddr", s_rf_waddr, m_waddr);
    end
    chk("arch_flags", arch_flags, m_flags);
    chk("s_arch_flags", s_arch_flags, m_flags);
    chk("retired", retired_cnt, m_ret);
    chk("condfail", condfail_cnt, m_cf);
    chk("s_retired", s_retired_cnt, 4'(m_ret));
    chk("s_condfail", s_condfail_cnt, 4'(m_cf));
    if (s_fwd_e_valid) begin
      chk("s_fwd_rd", s_fwd_e_rd, fwd_e_rd);
      chk("s_fwd_data", s_fwd_e_data, m_eres);
    end
  endtask

  op_t  nop;
  vec_t vt[14];

  initial begin
    nop = mkop(0, 0, 0, 0, 14, ALU_ADD, 32'd0, 32'd0, 0);
    m_ev = 0; m_e = nop; m_eres = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
    m_flags = '0; m_ret = 0; m_cf = 0;

    vt[0].op  = mkop(1, 3, 1, 0, 14, ALU_ADD, 32'd5, 32'd7, 0);
    vt[1].op  = mkop(1, 0, 0, 1, 14, ALU_SUB, 32'd4, 32'd4, 0);
    vt[2].op  = mkop(1, 1, 1, 0, 0, ALU_ADD, 32'd1, 32'd1, 0);
    vt[3].op  = mkop(1, 4, 1, 1, 14, ALU_SUB, 32'd3, 32'd5, 0);
    vt[4].op  = mkop(1, 2, 1, 0, 4, ALU_ORR, 32'hF0, 32'h0F, 0);
    vt[5].op  = mkop(1, 5, 1, 0, 5, ALU_ADD, 32'd9, 32'd1, 0);
    vt[6].op  = mkop(1, 0, 0, 1, 14, ALU_SUB, 32'd2, 32'd2, 0);
    vt[7].op  = mkop(1, 6, 1, 1, 1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    vt[8].op  = nop;
    vt[9].op  = mkop(1, 7, 1, 0, 14, ALU_ADD, 32'd1, 32'd2, 0);
    vt[10].op = mkop(1, 8, 1, 0, 14, ALU_ADD, 32'd3, 32'd3, 1);
    vt[11].op = mkop(1, 9, 1, 0, 14, ALU_ADD, 32'd4, 32'd4, 0);
    vt[12].op = nop;
    vt[13].op = nop;
    // {we, waddr, wdata, flags, retired, condfail} seen after each row's edge
    {vt[0].ewe,  vt[0].ewaddr,  vt[0].ewdata,  vt[0].eflags,  vt[0].eret,  vt[0].ecf}  = {1'b0, 4'd0, 32'd0,          4'b0000, 32'd0, 32'd0};
    {vt[1].ewe,  vt[1].ewaddr,  vt[1].ewdata,  vt[1].eflags,  vt[1].eret,  vt[1].ecf}  = {1'b1, 4'd3, 32'd12,         4'b0000, 32'd1, 32'd0};
    {vt[2].ewe,  vt[2].ewaddr,  vt[2].ewdata,  vt[2].eflags,  vt[2].eret,  vt[2].ecf}  = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd2, 32'd0};
    {vt[3].ewe,  vt[3].ewaddr,  vt[3].ewdata,  vt[3].eflags,  vt[3].eret,  vt[3].ecf}  = {1'b1, 4'd1, 32'd2,          4'b0100, 32'd3, 32'd0};
    {vt[4].ewe,  vt[4].ewaddr,  vt[4].ewdata,  vt[4].eflags,  vt[4].eret,  vt[4].ecf}  = {1'b1, 4'd4, 32'hFFFF_FFFE,  4'b1000, 32'd4, 32'd0};
    {vt[5].ewe,  vt[5].ewaddr,  vt[5].ewdata,  vt[5].eflags,  vt[5].eret,  vt[5].ecf}  = {1'b1, 4'd2, 32'hFF,         4'b1000, 32'd5, 32'd0};
    {vt[6].ewe,  vt[6].ewaddr,  vt[6].ewdata,  vt[6].eflags,  vt[6].eret,  vt[6].ecf}  = {1'b0, 4'd0, 32'd0,          4'b1000, 32'd5, 32'd1};
    {vt[7].ewe,  vt[7].ewaddr,  vt[7].ewdata,  vt[7].eflags,  vt[7].eret,  vt[7].ecf}  = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd6, 32'd1};
    {vt[8].ewe,  vt[8].ewaddr,  vt[8].ewdata,  vt[8].eflags,  vt[8].eret,  vt[8].ecf}  = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd6, 32'd2};
    {vt[9].ewe,  vt[9].ewaddr,  vt[9].ewdata,  vt[9].eflags,  vt[9].eret,  vt[9].ecf}  = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd6, 32'd2};
    {vt[10].ewe, vt[10].ewaddr, vt[10].ewdata, vt[10].eflags, vt[10].eret, vt[10].ecf} = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd6, 32'd2};
    {vt[11].ewe, vt[11].ewaddr, vt[11].ewdata, vt[11].eflags, vt[11].eret, vt[11].ecf} = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd6, 32'd2};
    {vt[12].ewe, vt[12].ewaddr, vt[12].ewdata, vt[12].eflags, vt[12].eret, vt[12].ecf} = {1'b1, 4'd9, 32'd8,          4'b0100, 32'd7, 32'd2};
    {vt[13].ewe, vt[13].ewaddr, vt[13].ewdata, vt[13].eflags, vt[13].eret, vt[13].ecf} = {1'b0, 4'd0, 32'd0,          4'b0100, 32'd7, 32'd2};

    @(posedge clk);
    #1;
    cycle(nop, 1);
    cycle(nop, 1);
    chk("reset_we", rf_we, 0);
    chk("reset_flags", arch_flags, 0);
    chk("reset_ret", retired_cnt, 0);
    chk("reset_cf", condfail_cnt, 0);

    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].op, 0);
      chk($sformatf("vec%0d_we", i), rf_we, vt[i].ewe);
      if (vt[i].ewe) begin
        chk($sformatf("vec%0d_waddr", i), rf_waddr, vt[i].ewaddr);
        chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].ewdata);
      end
      chk($sformatf("vec%0d_flags", i), arch_flags, vt[i].eflags);
      chk($sformatf("vec%0d_ret", i), retired_cnt, vt[i].eret);
      chk($sformatf("vec%0d_cf", i), condfail_cnt, vt[i].ecf);
    end

    // counter wrap on the 4-bit instance: 16 back-to-back AL ops
    cycle(nop, 1);
    for (int i = 0; i < 16; i++)
      cycle(mkop(1, i, 1, 0, 14, ALU_ADD, 32'(i), 32'd1, 0), 0);
    cycle(nop, 0);
    chk("wrap_ret32", retired_cnt, 16);
    chk("wrap_small", s_retired_cnt, 0);

    // NV always fails and counts as cond-fail
    cycle(mkop(1, 3, 1, 1, 15, ALU_ADD, 32'd1, 32'd1, 0), 0);
    cycle(nop, 0);
    chk("nv_we", rf_we, 0);
    chk("nv_cf", condfail_cnt, 1);

    // reset while an op sits in E and flags are nonzero
    cycle(mkop(1, 0, 0, 1, 14, ALU_SUB, 32'd1, 32'd1, 0), 0);
    cycle(mkop(1, 5, 1, 0, 14, ALU_ADD, 32'd2, 32'd2, 0), 0);
    chk("pre_rst_flags", arch_flags, 4'b0100);
    cycle(nop, 1);
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_flags", arch_flags, 0);
    chk("rst_mid_ret", retired_cnt, 0);
    cycle(nop, 0);
    chk("rst_after_we", rf_we, 0);

    for (int i = 0; i < 400; i++) begin
      op_t o;
      o = mkop(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), alu_func_e'($urandom_range(0, 4)),
               $urandom, (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom),
               ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 7) == 0) o.b = o.a;
      cycle(o, ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
